// File: rtl/data_mem.sv
// Single-port synchronous data memory (16-bit words) with post-reset hardware zero-fill.
// Optional macro DATA_MEM_OUTREG_EN adds a second output register (read latency 2).
module data_mem #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int PORT_AW = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PORT_AW-1:0] address,
  input  logic [DATA_W-1:0]  data,
  input  logic               wren,
  output logic [DATA_W-1:0]  q,
  output logic               busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] rd_q;

  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;

  generate
    if (PORT_AW > ADDR_W) begin : g_hi
      wire unused_addr_hi = ^address[PORT_AW-1:ADDR_W];
    end
  endgenerate

  // One RAM port shared between the fill engine and normal traffic.
  always_comb begin
    ram_a  = address[ADDR_W-1:0];
    ram_d  = data;
    ram_we = wren & reset_n;
    if (busy) begin
      ram_a  = fill_cnt;
      ram_d  = '0;
      ram_we = reset_n;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_a] <= ram_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy     <= 1'b1;
      fill_cnt <= '0;
      rd_q     <= '0;
    end else if (busy) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (&fill_cnt) busy <= 1'b0;
      rd_q     <= '0;
    end else begin
      rd_q     <= mem[ram_a];
    end
  end

`ifdef DATA_MEM_OUTREG_EN
  always_ff @(posedge clock) begin
    if (!reset_n) q <= '0;
    else          q <= rd_q;
  end
`else
  assign q = rd_q;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset/fill, write sweep, read-during-write,
// aliasing, ignored writes and mid-operation reset.
module tb_data_mem;
`ifdef DATA_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [15:0] data;
  logic        wren;
  logic [15:0] q;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  data_mem dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data(data),
    .wren(wren), .q(q), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return {8'h00, r};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives a read and waits out the read latency; comparisons are done by callers.
  task automatic do_read(input logic [15:0] a);
    address = a;
    wren    = 1'b0;
    data    = 16'hFFFF;
    repeat (LAT) tick();
  endtask

  task automatic wait_fill(output int cycles);
    cycles = 0;
    while (busy && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset_n = 1'b0; wren = 1'b0; address = 16'h0000; data = 16'h0000;
    repeat (3) tick();
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL reset_q: got %h want 0000", q); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    // wren held high through the fill must not land.
    address = 16'h0033; data = 16'hDEAD; wren = 1'b1;
    reset_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 100) begin
        n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL fill_q: got %h want 0000", q); end
      end
    end
    wren = 1'b0;
    n_cmp++; if (cyc !== 256) begin n_err++; $display("FAIL fill_len: got %0d want 256", cyc); end
    do_read(16'h0033);
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL fill_ignored_wr: got %h want 0000", q); end
    do_read(16'h0000);
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL fill_w0: got %h want 0000", q); end
    do_read(16'h00FF);
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL fill_wff: got %h want 0000", q); end
  endtask

  task automatic test_write_sweep();
    logic [7:0] probes [6];
    probes = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'h5A, 8'h37};
    for (int i = 0; i < 256; i++) begin
      address = 16'(i); data = rev8(8'(i)); wren = 1'b1;
      tick();
    end
    wren = 1'b0; data = ~data;
    tick();
    for (int k = 0; k < 6; k++) begin
      do_read({8'h00, probes[k]});
      n_cmp++;
      if (q !== rev8(probes[k])) begin
        n_err++; $display("FAIL sweep_rd[%h]: got %h want %h", probes[k], q, rev8(probes[k]));
      end
    end
    do_read(16'h0080);
    n_cmp++; if (q !== 16'h0001) begin n_err++; $display("FAIL sweep_80: got %h want 0001", q); end
    do_read(16'h0001);
    n_cmp++; if (q !== 16'h0080) begin n_err++; $display("FAIL sweep_01: got %h want 0080", q); end
  endtask

  task automatic test_rdw();
    address = 16'h0010; data = 16'h1234; wren = 1'b1;
    tick();
    data = 16'hBEEF; wren = 1'b1;
    tick();
    wren = 1'b0; data = 16'h0000;
    repeat (LAT-1) tick();
    n_cmp++; if (q !== 16'h1234) begin n_err++; $display("FAIL rdw_old: got %h want 1234", q); end
    tick();
    n_cmp++; if (q !== 16'hBEEF) begin n_err++; $display("FAIL rdw_new: got %h want beef", q); end
  endtask

  task automatic test_alias();
    address = 16'h0305; data = 16'hA5A5; wren = 1'b1;
    tick();
    wren = 1'b0;
    do_read(16'h0005);
    n_cmp++; if (q !== 16'hA5A5) begin n_err++; $display("FAIL alias_0005: got %h want a5a5", q); end
    do_read(16'hFF05);
    n_cmp++; if (q !== 16'hA5A5) begin n_err++; $display("FAIL alias_ff05: got %h want a5a5", q); end
    do_read({8'hxx, 8'h05});
    n_cmp++; if (q !== 16'hA5A5) begin n_err++; $display("FAIL alias_xx05: got %h want a5a5", q); end
    do_read(16'hFFFF);
    n_cmp++; if (q !== 16'h00FF) begin n_err++; $display("FAIL alias_ffff: got %h want 00ff", q); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    do_read(16'h0080);
    address = 16'h0080;
    reset_n = 1'b0;
    tick();
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL midrst_q: got %h want 0000", q); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b want 1", busy); end
    reset_n = 1'b1;
    repeat (50) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midfill_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_fill(cyc);
    n_cmp++; if (cyc !== 256) begin n_err++; $display("FAIL refill_len: got %0d want 256", cyc); end
    do_read(16'h0010);
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL refill_10: got %h want 0000", q); end
    do_read(16'h0080);
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL refill_80: got %h want 0000", q); end
    do_read(16'h0005);
    n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL refill_05: got %h want 0000", q); end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_rdw();
    test_alias();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
